fact_bus_master: RTL

Hardware initiator for the factorial peripheral's 2-bit-address register bus. On each accepted request it writes the operand register, pulses go, polls status until done or error, reads the result, and returns a single response. It stands in for the CPU-side driver, so accelerator jobs run without software polling. It sits between a request/response client and one factorial register slave.

---
 rtl/fact_pkg.sv | 83 ++++++++
 rtl/fact_poll_counter.sv | 42 ++++
 rtl/fact_bus_master.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fact_pkg.sv
// Shared definitions for the factorial register-bus master: bus address map,
// status bit positions, FSM state encoding and the per-state bus decode.
package fact_pkg;

    // Register map of the factorial slave
    localparam logic [1:0] FACT_A_N      = 2'd0;
    localparam logic [1:0] FACT_A_GO     = 2'd1;
    localparam logic [1:0] FACT_A_STATUS = 2'd2;
    localparam logic [1:0] FACT_A_RESULT = 2'd3;

    // Status register bit positions
    localparam int unsigned FACT_ST_DONE = 1;
    localparam int unsigned FACT_ST_ERR  = 0;

    // Poll counter width; the counter saturates instead of wrapping
    localparam int unsigned POLL_CNT_W = 16;

    // State encoding
    localparam logic [3:0] ST_IDLE_ENC      = 4'd0;
    localparam logic [3:0] ST_WR_N_ENC      = 4'd1;
    localparam logic [3:0] ST_WR_GO_ENC     = 4'd2;
    localparam logic [3:0] ST_WR_GO_CLR_ENC = 4'd3;
    localparam logic [3:0] ST_POLL_A_ENC    = 4'd4;
    localparam logic [3:0] ST_POLL_S_ENC    = 4'd5;
    localparam logic [3:0] ST_RES_A_ENC     = 4'd6;
    localparam logic [3:0] ST_RES_S_ENC     = 4'd7;
    localparam logic [3:0] ST_RESP_ENC      = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE      = ST_IDLE_ENC,
        ST_WR_N      = ST_WR_N_ENC,
        ST_WR_GO     = ST_WR_GO_ENC,
        ST_WR_GO_CLR = ST_WR_GO_CLR_ENC,
        ST_POLL_A    = ST_POLL_A_ENC,
        ST_POLL_S    = ST_POLL_S_ENC,
        ST_RES_A     = ST_RES_A_ENC,
        ST_RES_S     = ST_RES_S_ENC,
        ST_RESP      = ST_RESP_ENC
    } fact_state_e;

    // Bus command driven towards the slave
    typedef struct packed {
        logic [1:0] a;
        logic       we;
        logic [3:0] wd;
    } fact_bus_t;

    // Response returned to the client
    typedef struct packed {
        logic [31:0] result;
        logic        err;
        logic        timeout;
    } fact_rsp_t;

    // Bus command belonging to a state. Non-write states keep we/wd at zero,
    // and every state without a register access parks the address at 0.
    function automatic fact_bus_t fact_bus_cmd(input fact_state_e st, input logic [3:0] n);
        fact_bus_t cmd;
        cmd = '0;
        case (st)
            ST_WR_N: begin
                cmd.a  = FACT_A_N;
                cmd.we = 1'b1;
                cmd.wd = n;
            end
            ST_WR_GO: begin
                cmd.a  = FACT_A_GO;
                cmd.we = 1'b1;
                cmd.wd = 4'd1;
            end
            ST_WR_GO_CLR: begin
                cmd.a  = FACT_A_GO;
                cmd.we = 1'b1;
                cmd.wd = 4'd0;
            end
            ST_POLL_A, ST_POLL_S: cmd.a = FACT_A_STATUS;
            ST_RES_A, ST_RES_S:   cmd.a = FACT_A_RESULT;
            default:              cmd = '0;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/fact_poll_counter.sv
// Clearable, saturating status-poll counter. at_limit_next flags that the
// increment happening this cycle lands exactly on LIMIT.
module fact_poll_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit_next
);
    import fact_pkg::*;

    localparam logic [POLL_CNT_W-1:0] LIMIT_W = POLL_CNT_W'(LIMIT);

    logic [POLL_CNT_W-1:0] cnt_q;
    logic [POLL_CNT_W-1:0] cnt_d;
    logic [POLL_CNT_W-1:0] cnt_inc;

    // Next count: clear wins over increment; increment sticks at all-ones
    always_comb begin
        cnt_inc = (cnt_q == {POLL_CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_inc;
        end
    end

    assign at_limit_next = (cnt_inc == LIMIT_W);

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fact_bus_master.sv
// Bus initiator for the factorial peripheral: writes n, pulses go, polls
// status, fetches the result and hands one response back to the client.
module fact_bus_master #(
    parameter int unsigned POLL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_n,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [1:0]  bus_a,
    output logic        bus_we,
    output logic [3:0]  bus_wd,
    input  logic [31:0] bus_rd
);
    import fact_pkg::*;

    fact_state_e state_q, state_d;
    fact_bus_t   bus_q, bus_d;
    logic [3:0]  n_q, n_d;
    fact_rsp_t   rsp_q, rsp_d;

    logic poll_clr;
    logic poll_inc;
    logic poll_last;
    logic st_done;
    logic st_err;

    assign st_done = bus_rd[FACT_ST_DONE];
    assign st_err  = bus_rd[FACT_ST_ERR];

    fact_poll_counter #(
        .LIMIT(POLL_LIMIT)
    ) u_poll_counter (
        .clk          (clk),
        .rst          (rst),
        .clr          (poll_clr),
        .inc          (poll_inc),
        .at_limit_next(poll_last)
    );

    // Next-state decode and the bus command for the state being entered
    always_comb begin
        state_d  = state_q;
        poll_clr = 1'b0;
        poll_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d  = ST_WR_N;
                    poll_clr = 1'b1;
                end
            end
            ST_WR_N:      state_d = ST_WR_GO;
            ST_WR_GO:     state_d = ST_WR_GO_CLR;
            ST_WR_GO_CLR: state_d = ST_POLL_A;
            ST_POLL_A:    state_d = ST_POLL_S;
            ST_POLL_S: begin
                poll_inc = 1'b1;
                if (st_err) begin
                    state_d = ST_RESP;
                end else if (st_done) begin
                    state_d = ST_RES_A;
                end else if (poll_last) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_POLL_A;
                end
            end
            ST_RES_A:     state_d = ST_RES_S;
            ST_RES_S:     state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default:      state_d = ST_IDLE;
        endcase
        bus_d = fact_bus_cmd(state_d, n_d);
    end

    // FSM state and registered bus outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
        end
    end

    // Operand latch and response accumulation
    always_comb begin
        n_d   = n_q;
        rsp_d = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    n_d = req_n;
                end
            end
            ST_POLL_S: begin
                if (st_err) begin
                    rsp_d.err = 1'b1;
                end else if (!st_done && poll_last) begin
                    rsp_d.timeout = 1'b1;
                end
            end
            ST_RES_S: rsp_d.result = bus_rd;
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q   <= '0;
            rsp_q <= '0;
        end else begin
            n_q   <= n_d;
            rsp_q <= rsp_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_result  = rsp_q.result;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;
    assign bus_a       = bus_q.a;
    assign bus_we      = bus_q.we;
    assign bus_wd      = bus_q.wd;

endmodule
